fxp_divider_signed: RTL

- Parametrised signed fixed-point divider. Successor to the unsigned 16-bit Q9.7 iterative divider.
- Adds generic width/fraction, two's-complement operands, saturation, divide-by-zero and overflow flags, busy indication and fixed latency.
- Serves the RK4 neuron datapath: step-size and coefficient divisions on Qm.f state variables.
- Computes one quotient bit per clock by restoring division on magnitudes.

---
 rtl/fxp_divider_signed.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fxp_divider_signed.sv
// Signed Q(WIDTH-FRAC).FRAC divider: restoring division on magnitudes, one quotient
// bit per clock, saturating result with divide-by-zero and overflow flags.
//
// state  | meaning
// IDLE   | waiting for start; last result and flags held
// DIVIDE | one restoring iteration per clock, WIDTH+FRAC iterations
// FINISH | apply sign / saturation, pulse done
module fxp_divider_signed #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int NW = WIDTH + FRAC;
    localparam int CW = $clog2(NW + 1);
    localparam logic [NW-1:0]    MAX_MAG = NW'((64'd1 << (WIDTH - 1)) - 64'd1);
    localparam logic [NW-1:0]    MIN_MAG = NW'(64'd1 << (WIDTH - 1));
    localparam logic [WIDTH-1:0] MAX_Q   = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_Q   = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;

    state_t state, state_next;

    // num starts as the shifted numerator and fills with quotient bits from the LSB
    logic [NW-1:0]    num;
    logic [WIDTH-1:0] den;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    count;
    logic             sign;
    logic             dz;
    logic             dividend_neg;
    logic             dividend_zero;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] q_low;
    logic [WIDTH-1:0] q_neg;

    // |min| wraps to 2^(WIDTH-1) which is exactly right as an unsigned magnitude
    assign dividend_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    assign divisor_mag  = divisor[WIDTH-1]  ? (~divisor + WIDTH'(1))  : divisor;
    assign shifted      = {rem, num[NW-1]};
    assign ge           = shifted >= {1'b0, den};
    assign q_low        = num[WIDTH-1:0];
    assign q_neg        = ~q_low + WIDTH'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = DIVIDE;
            DIVIDE:  if (count == CW'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num           <= '0;
            den           <= '0;
            rem           <= '0;
            count         <= '0;
            sign          <= 1'b0;
            dz            <= 1'b0;
            dividend_neg  <= 1'b0;
            dividend_zero <= 1'b0;
            quotient      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            div_by_zero   <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign          <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        num           <= NW'(dividend_mag) << FRAC;
                        den           <= divisor_mag;
                        dz            <= (divisor == '0);
                        dividend_neg  <= dividend[WIDTH-1];
                        dividend_zero <= (dividend == '0);
                        rem           <= '0;
                        count         <= CW'(NW);
                        busy          <= 1'b1;
                    end
                end
                DIVIDE: begin
                    // remainder stays below den, so the low WIDTH bits suffice
                    rem   <= ge ? (shifted[WIDTH-1:0] - den) : shifted[WIDTH-1:0];
                    num   <= {num[NW-2:0], ge};
                    count <= count - CW'(1);
                end
                FINISH: begin
                    if (dz) begin
                        quotient    <= dividend_zero ? '0 : (dividend_neg ? MIN_Q : MAX_Q);
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else if (!sign && num > MAX_MAG) begin
                        quotient    <= MAX_Q;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b1;
                    end else if (sign && num > MIN_MAG) begin
                        quotient    <= MIN_Q;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b1;
                    end else begin
                        quotient    <= sign ? q_neg : q_low;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
